// File: rtl/factor_seq_pkg.sv
// Shared states, constants and helpers for the factorization job sequencer.
package factor_seq_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, RESP} state_e;

  localparam logic [31:0] SEED_STEP = 32'h9E3779B9;
  localparam int          MIN_N     = 9;
  localparam int          WDOG_W    = 24;

  // N is split into a 4-bit MSB slice and two equal lower slices of this width.
  function automatic int n_low_width(input int n_digit);
    return n_digit / 2 - 2;
  endfunction

  function automatic logic [31:0] attempt_seed(input logic [31:0] base, input logic [3:0] attempt);
    logic [31:0] s;
    s = base + ({28'd0, attempt} * SEED_STEP);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

endpackage

// File: rtl/factor_check.sv
// Two-stage factor check: captures X/Y/N, then registers ok = (X*Y==N) && X!=1 && Y!=1.
module factor_check #(
  parameter int HALF_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [HALF_W-1:0]     x_i,
  input  logic [HALF_W-1:0]     y_i,
  input  logic [2*HALF_W-1:0]   n_i,
  output logic                  ok_o,
  output logic                  done_o
);

  logic [HALF_W-1:0]   x_q, y_q;
  logic [2*HALF_W-1:0] n_q;
  logic [2*HALF_W-1:0] prod;
  logic                stage_q, ok_q, done_q;

  assign prod = {{HALF_W{1'b0}}, x_q} * {{HALF_W{1'b0}}, y_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      stage_q <= 1'b0;
      ok_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      stage_q <= valid_i;
      done_q  <= stage_q;
      if (valid_i) begin
        x_q <= x_i;
        y_q <= y_i;
        n_q <= n_i;
      end
      if (stage_q) begin
        ok_q <= (prod == n_q) && (x_q != HALF_W'(1)) && (y_q != HALF_W'(1));
      end
    end
  end

  assign ok_o   = ok_q;
  assign done_o = done_q;

endmodule

// File: rtl/factor_job_sequencer.sv
// Job controller around the p-bit factorization engine: launch, check, retry, respond.
// Optional FACTOR_SEQ_WATCHDOG_EN aborts an attempt after 2^24-1 RUN cycles without eng_end.
module factor_job_sequencer
  import factor_seq_pkg::*;
#(
  parameter int MAX_N_DIGIT = 64,
  parameter int COUNTER_BIT = 32,
  parameter int MAX_RETRY   = 8,
  parameter int OPS_W       = COUNTER_BIT + 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [MAX_N_DIGIT-1:0]   req_N_i,
  input  logic [31:0]              req_seed_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic                     resp_ok_o,
  output logic                     resp_err_o,
  output logic [MAX_N_DIGIT/2-1:0] resp_X_o,
  output logic [MAX_N_DIGIT/2-1:0] resp_Y_o,
  output logic [3:0]               resp_tries_o,
  output logic [OPS_W-1:0]         resp_ops_o,
  output logic                     eng_start_o,
  output logic [31:0]              eng_seed_o,
  output logic [3:0]               eng_N_MSB_o,
  output logic [MAX_N_DIGIT/2-3:0] eng_N_MID_o,
  output logic [MAX_N_DIGIT/2-3:0] eng_N_LSB_o,
  input  logic                     eng_end_i,
  input  logic [COUNTER_BIT-1:0]   eng_count_i,
  input  logic [MAX_N_DIGIT/2-1:0] eng_X_i,
  input  logic [MAX_N_DIGIT/2-1:0] eng_Y_i
);

  localparam int         HALF_W   = MAX_N_DIGIT / 2;
  localparam int         LOW_W    = n_low_width(MAX_N_DIGIT);
  localparam logic [3:0] LAST_TRY = 4'(MAX_RETRY - 1);

  state_e                 state_q;
  logic [MAX_N_DIGIT-1:0] n_q, eng_n_q;
  logic [31:0]            seed_q, eng_seed_q;
  logic [3:0]             attempt_q, resp_tries_q;
  logic [OPS_W-1:0]       ops_q, ops_add;
  logic [OPS_W:0]         ops_sum;
  logic [HALF_W-1:0]      resp_x_q, resp_y_q;
  logic                   eng_start_q, resp_valid_q, resp_ok_q, resp_err_q;
  logic                   reject, run_done, attempt_ok, chk_ok, chk_done;

`ifdef FACTOR_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              abort_q;
`endif

  assign reject  = !req_N_i[0] || (req_N_i < MAX_N_DIGIT'(MIN_N));
  assign ops_sum = {1'b0, ops_q} + {{(OPS_W + 1 - COUNTER_BIT){1'b0}}, eng_count_i};
  assign ops_add = ops_sum[OPS_W] ? {OPS_W{1'b1}} : ops_sum[OPS_W-1:0];

  always_comb begin
    run_done   = eng_end_i;
    attempt_ok = chk_ok;
`ifdef FACTOR_SEQ_WATCHDOG_EN
    run_done   = eng_end_i || (wdog_q == {WDOG_W{1'b1}});
    attempt_ok = chk_ok && !abort_q;
`endif
  end

  factor_check #(.HALF_W(HALF_W)) u_check (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i ((state_q == RUN) && run_done),
    .x_i     (eng_X_i),
    .y_i     (eng_Y_i),
    .n_i     (n_q),
    .ok_o    (chk_ok),
    .done_o  (chk_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      n_q          <= '0;
      seed_q       <= '0;
      attempt_q    <= '0;
      ops_q        <= '0;
      eng_start_q  <= 1'b0;
      eng_seed_q   <= 32'd1;
      eng_n_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_x_q     <= '0;
      resp_y_q     <= '0;
      resp_tries_q <= '0;
`ifdef FACTOR_SEQ_WATCHDOG_EN
      wdog_q       <= '0;
      abort_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (req_valid_i) begin
          n_q       <= req_N_i;
          seed_q    <= req_seed_i;
          attempt_q <= '0;
          ops_q     <= '0;
          resp_x_q  <= '0;
          resp_y_q  <= '0;
          if (reject) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_ok_q    <= 1'b0;
            resp_tries_q <= '0;
            state_q      <= RESP;
          end else begin
            resp_err_q <= 1'b0;
            eng_n_q    <= req_N_i;
            eng_seed_q <= attempt_seed(req_seed_i, 4'd0);
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          eng_start_q <= 1'b1;
          state_q     <= RUN;
`ifdef FACTOR_SEQ_WATCHDOG_EN
          wdog_q      <= '0;
`endif
        end
        RUN: begin
`ifdef FACTOR_SEQ_WATCHDOG_EN
          wdog_q <= wdog_q + 1'b1;
          if (run_done) abort_q <= !eng_end_i;
`endif
          if (run_done) begin
            resp_x_q <= eng_X_i;
            resp_y_q <= eng_Y_i;
            ops_q    <= ops_add;
            state_q  <= CHECK;
          end
        end
        // Engine stays started through CHECK so its X/Y remain valid.
        CHECK: if (chk_done) begin
          eng_start_q <= 1'b0;
          if (attempt_ok || (attempt_q == LAST_TRY)) begin
            resp_ok_q    <= attempt_ok;
            resp_tries_q <= attempt_q + 4'd1;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            attempt_q  <= attempt_q + 4'd1;
            eng_seed_q <= attempt_seed(seed_q, attempt_q + 4'd1);
            state_q    <= LOAD;
          end
        end
        RESP: if (resp_ready_i) begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_ok_o    = resp_ok_q;
  assign resp_err_o   = resp_err_q;
  assign resp_X_o     = resp_x_q;
  assign resp_Y_o     = resp_y_q;
  assign resp_tries_o = resp_tries_q;
  assign resp_ops_o   = ops_q;
  assign eng_start_o  = eng_start_q;
  assign eng_seed_o   = eng_seed_q;
  assign eng_N_MSB_o  = eng_n_q[MAX_N_DIGIT-1 -: 4];
  assign eng_N_MID_o  = eng_n_q[2*LOW_W-1 -: LOW_W];
  assign eng_N_LSB_o  = eng_n_q[LOW_W-1:0];

  // LOAD holds the engine in reset, so completion on the first RUN cycle is an engine fault.
  first_run_no_end: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((state_q == RUN) && ($past(state_q) == LOAD)) |-> !eng_end_i);

endmodule

// File: tb/tb_factor_job_sequencer.sv
// Randomized self-checking bench for factor_job_sequencer with a scripted engine model.
module tb_factor_job_sequencer;

  localparam int MAXR = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid, reqReady;
  logic [63:0] reqN;
  logic [31:0] reqSeed;
  logic        respValid, respReady, respOk, respErr;
  logic [31:0] respX, respY;
  logic [3:0]  respTries;
  logic [35:0] respOps;
  logic        engStart;
  logic [31:0] engSeed;
  logic [3:0]  engNMsb;
  logic [29:0] engNMid, engNLsb;
  logic        engEnd = 1'b0;
  logic [31:0] engCount = '0, engX = '0, engY = '0;

  logic [31:0] scrX[MAXR], scrY[MAXR], scrCnt[MAXR];
  int          scrLat[MAXR];
  int          attemptIdx = 0, curAttempt = 0, runCycles = 0, lowCycles = 0, risesInJob = 0;
  logic        prevStart = 1'b0;
  logic [63:0] jobN = '0;
  logic [31:0] jobSeed = '0;
  int          vectorCount = 0, missCount = 0;

  factor_job_sequencer dut (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_N_i(reqN), .req_seed_i(reqSeed),
    .resp_valid_o(respValid), .resp_ready_i(respReady), .resp_ok_o(respOk), .resp_err_o(respErr),
    .resp_X_o(respX), .resp_Y_o(respY), .resp_tries_o(respTries), .resp_ops_o(respOps),
    .eng_start_o(engStart), .eng_seed_o(engSeed),
    .eng_N_MSB_o(engNMsb), .eng_N_MID_o(engNMid), .eng_N_LSB_o(engNLsb),
    .eng_end_i(engEnd), .eng_count_i(engCount), .eng_X_i(engX), .eng_Y_i(engY)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] seedFor(input logic [31:0] base, input int idx);
    logic [63:0] s;
    s = {32'd0, base} + 64'(idx) * 64'h9E3779B9;
    return (s[31:0] == 32'd0) ? 32'd1 : s[31:0];
  endfunction

  // Engine model: each rising eng_start begins the next scripted attempt; results hold until start drops.
  always @(negedge clk) begin
    if (!engStart) begin
      engEnd = 1'b0; engX = '0; engY = '0; engCount = '0;
      runCycles = 0;
      lowCycles++;
    end else begin
      if (!prevStart) begin
        risesInJob++;
        checkOutput("eng_seed", engSeed, seedFor(jobSeed, attemptIdx));
        checkOutput("eng_N", {engNMsb, engNMid, engNLsb}, jobN);
        if (attemptIdx > 0) checkOutput("start_gap", lowCycles, 1);
        curAttempt = (attemptIdx < MAXR) ? attemptIdx : MAXR - 1;
        attemptIdx++;
        lowCycles = 0;
      end
      runCycles++;
      if (runCycles >= scrLat[curAttempt]) begin
        engEnd = 1'b1; engX = scrX[curAttempt]; engY = scrY[curAttempt]; engCount = scrCnt[curAttempt];
      end
    end
    prevStart = engStart;
  end

  task automatic fillFail(input logic [31:0] n);
    for (int i = 0; i < MAXR; i++) begin
      scrX[i] = 32'd1; scrY[i] = n; scrCnt[i] = $urandom; scrLat[i] = $urandom_range(2, 6);
    end
  endtask

  task automatic checkResp(input string ph, input logic expErr, input logic expOk, input int expTries,
                           input logic [35:0] expOps, input logic [31:0] expX, input logic [31:0] expY);
    checkOutput({ph, "_valid"}, respValid, 1);
    checkOutput({ph, "_req_ready"}, reqReady, 0);
    checkOutput({ph, "_err"}, respErr, expErr);
    checkOutput({ph, "_ok"}, respOk, expOk);
    checkOutput({ph, "_tries"}, respTries, expTries);
    checkOutput({ph, "_ops"}, respOps, expOps);
    if (!expErr) begin
      checkOutput({ph, "_x"}, respX, expX);
      checkOutput({ph, "_y"}, respY, expY);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] n, input logic [31:0] seed, input int holdCycles);
    logic        expErr, expOk;
    int          expTries, waitCycles;
    logic [35:0] expOps;
    logic [36:0] sum;
    logic [31:0] expX, expY;
    expErr = !n[0] || (n < 64'd9);
    expOk = 1'b0; expTries = 0; expOps = '0; expX = '0; expY = '0;
    if (!expErr) begin
      for (int i = 0; i < MAXR; i++) begin
        sum = {1'b0, expOps} + 37'(scrCnt[i]);
        expOps = sum[36] ? '1 : sum[35:0];
        expX = scrX[i]; expY = scrY[i]; expTries = i + 1;
        if (({32'd0, scrX[i]} * {32'd0, scrY[i]} == n) && scrX[i] != 1 && scrY[i] != 1) begin
          expOk = 1'b1;
          break;
        end
      end
    end
    jobN = n; jobSeed = seed; attemptIdx = 0; risesInJob = 0;
    @(negedge clk);
    checkOutput("idle_ready", reqReady, 1);
    reqN = n; reqSeed = seed; reqValid = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("accept_busy", reqReady, 0);
    if (expErr) checkOutput("err_latency", respValid, 1);
    waitCycles = 0;
    while (!respValid && waitCycles < 4000) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!respValid) begin
      checkOutput("resp_timeout", respValid, 1);
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      return;
    end
    checkResp("resp", expErr, expOk, expTries, expOps, expX, expY);
    checkOutput("engine_runs", risesInJob, expErr ? 0 : expTries);
    for (int h = 0; h < holdCycles; h++) begin
      reqN = ~n; reqValid = 1'b1;
      @(negedge clk);
      checkResp("hold", expErr, expOk, expTries, expOps, expX, expY);
    end
    reqValid = 1'b0; respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
    checkOutput("resp_drop", respValid, 0);
    checkOutput("ready_back", reqReady, 1);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [63:0] n;
    int          k;
    rstN = 1'b0; reqValid = 1'b0; respReady = 1'b0; reqN = '0; reqSeed = '0;
    fillFail(32'd1);
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", reqReady, 1);
    checkOutput("rst_valid", respValid, 0);
    checkOutput("rst_start", engStart, 0);
    checkOutput("rst_seed", engSeed, 1);
    checkOutput("rst_engN", {engNMsb, engNMid, engNLsb}, 0);
    checkOutput("rst_ops", respOps, 0);
    checkOutput("rst_tries", respTries, 0);
    rstN = 1'b1;

    fillFail(32'd15);
    scrX[0] = 3; scrY[0] = 5; scrCnt[0] = 7; scrLat[0] = 3;
    applyStimulus(64'd15, 32'd7, 5);

    fillFail(32'd35);
    scrX[1] = 5; scrY[1] = 7;
    applyStimulus(64'd35, 32'h1234_5678, 0);

    fillFail(32'd221);
    applyStimulus(64'd221, 32'h61C88647, 0);

    applyStimulus(64'd14, 32'd3, 5);
    applyStimulus(64'd7, 32'd3, 0);

    // Reset while the engine is running drops eng_start at once and loses the job.
    fillFail(32'd15);
    for (int i = 0; i < MAXR; i++) scrLat[i] = 50;
    jobN = 64'd15; jobSeed = 32'd9; attemptIdx = 0;
    @(negedge clk);
    reqN = 64'd15; reqSeed = 32'd9; reqValid = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    k = 0;
    while (!engStart && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("run_reached", engStart, 1);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mid_rst_start", engStart, 0);
    checkOutput("mid_rst_valid", respValid, 0);
    checkOutput("mid_rst_seed", engSeed, 1);
    checkOutput("mid_rst_ops", respOps, 0);
    checkOutput("mid_rst_ready", reqReady, 1);
    @(negedge clk);
    rstN = 1'b1;
    fillFail(32'd15);
    scrX[0] = 5; scrY[0] = 3;
    applyStimulus(64'd15, 32'd11, 0);

    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 8)) : {$urandom, $urandom} & ~64'd1;
        applyStimulus(n, $urandom, $urandom_range(0, 2));
      end else begin
        x = 32'($urandom_range(3, 65535)) | 32'd1;
        y = 32'($urandom_range(3, 65535)) | 32'd1;
        n = {32'd0, x} * {32'd0, y};
        k = $urandom_range(0, 9);
        for (int i = 0; i < MAXR; i++) begin
          scrCnt[i] = $urandom; scrLat[i] = $urandom_range(2, 6);
          if (i == k) begin
            scrX[i] = x; scrY[i] = y;
          end else begin
            case ($urandom_range(0, 2))
              0:       begin scrX[i] = 32'd1; scrY[i] = n[31:0]; end
              1:       begin scrX[i] = n[31:0]; scrY[i] = 32'd1; end
              default: begin scrX[i] = x; scrY[i] = y + 32'd2; end
            endcase
          end
        end
        applyStimulus(n, $urandom, $urandom_range(0, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
